axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ID_WIDTH, default 13, width of AXI arid/rid.
REQ-002 Parameter ADDR_WIDTH, default 64, width of request and AR address.
REQ-003 Parameter DATA_WIDTH, default 64, width of R data.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 reqN_valid / reqN_ready  input / output  1 / 1  read-request handshake, N=0 (instruction fetch), N=1 (data load).
REQ-007 reqN_addr / reqN_len / reqN_size / reqN_burst  input  ADDR_WIDTH / 8 / 3 / 2  burst request fields, passed to AR unchanged.
REQ-008 rspN_valid / rspN_ready  output / input  1 / 1  per-requester response-beat handshake.
REQ-009 rspN_data / rspN_resp / rspN_last  output  DATA_WIDTH / 2 / 1  beat data, response code, last-beat flag.
REQ-010 m_axi_arid / araddr / arlen / arsize / arburst / arvalid  output  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 1  AXI AR channel; arready input 1.
REQ-011 m_axi_arlock / arcache / arprot  output  1 / 4 / 3  driven constant 0, 4'b0011, 3'b000.
REQ-012 m_axi_rid / rdata / rresp / rlast / rvalid  input  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  AXI R channel; rready output 1.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, latch its fields and index into a grant register, go to ADDR next cycle.
REQ-016 IDLE with both valid SHALL grant per arbitration policy of REQ-027/REQ-028; the loser's reqN_ready stays 0.
REQ-017 ADDR: arvalid=1 with all AR fields from latched registers, stable until arready; arid = {ID_WIDTH-1 zeros, grant index}.
REQ-018 ADDR with arready=1 SHALL move to DATA next cycle; arvalid deasserts after that cycle.
REQ-019 DATA: rspG_valid=m_axi_rvalid, rspG_data/resp/last = rdata/rresp/rlast, m_axi_rready=rspG_ready, G=granted port; non-granted rsp_valid=0.
REQ-020 DATA: beat with rvalid & rready & rlast SHALL return FSM to IDLE next cycle; new grant possible no earlier than the cycle after that (2-cycle minimum gap from last beat to next arvalid).
REQ-021 R beat with rid[0] not equal to grant index SHALL still be forwarded to granted port and SHALL set sticky output-internal flag id_err (cleared by reset only).
REQ-022 Beat counter (8 bits) SHALL count accepted beats; rlast arriving before count reaches latched len, or count exceeding len without rlast, SHALL also set id_err; transfer still ends only on rlast.
REQ-023 Backpressure from rspG_ready=0 SHALL hold m_axi_rready=0; no beat dropped or duplicated.
REQ-024 reqN_ready SHALL be 0 in ADDR and DATA.

Reset
REQ-025 On reset_n low (asynchronous, any state incl. mid-burst): state IDLE, arvalid=0, rready=0, all rsp_valid=0, reqN_ready=0, busy=0, grant=0, priority pointer=0, id_err=0, latched fields=0.
REQ-026 Release of reset_n SHALL allow a grant in the first following rising edge after IDLE evaluation; an in-flight AXI burst is abandoned without draining.

Configuration
REQ-027 Macro AXI_RD_ARB_RR_EN defined: round-robin; pointer holds last-granted index, simultaneous requests grant the other port; pointer updates on each grant.
REQ-028 Macro undefined: fixed priority, port 1 (data load) always wins simultaneous requests; pointer logic absent.

Verification
REQ-029 Single req0 addr=0x1000 len=7 size=2 burst=2, arready immediate, 8 beats -> one AR with arid=0, 8 rsp0 beats, last on 8th, back to IDLE, busy low.
REQ-030 req0 and req1 valid same cycle, repeated 4 bursts -> RR build grants 1,0,1,0 (pointer reset 0); fixed build grants 1,1,1,1.
REQ-031 arready held low 5 cycles in ADDR -> arvalid and fields stable all 5 cycles, single AR accepted.
REQ-032 rsp1_ready toggled 0/1 during 4-beat burst -> m_axi_rready mirrors it, exactly 4 beats delivered in order.
REQ-033 reset_n asserted on 3rd beat of 8-beat burst -> next cycle arvalid=0, rready=0, busy=0, rsp_valid=0.
REQ-034 rlast on beat 3 of len=7 burst -> FSM returns to IDLE, id_err=1 until reset.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address / read-data channel bundle for the two-port read arbiter.
// The master modport is the arbiter side and the slave modport is the memory side.
interface axi_rd_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-port (ifetch=0, load=1) AXI read arbiter with one burst outstanding at a time.
// Define AXI_RD_ARB_RR_EN to get round-robin arbitration; the default is fixed priority to port 1.
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]            req0_len,
  input  logic [2:0]            req0_size,
  input  logic [1:0]            req0_burst,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]            req1_len,
  input  logic [2:0]            req1_size,
  input  logic [1:0]            req1_burst,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic [1:0]            rsp0_resp,
  output logic                  rsp0_last,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [1:0]            rsp1_resp,
  output logic                  rsp1_last,
  axi_rd_arbiter_if.master      m_axi,
  output logic                  busy,
  output logic                  id_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_n;
  logic [1:0]                 req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][7:0]            req_len;
  logic [1:0][2:0]            req_size;
  logic [1:0][1:0]            req_burst;
  logic                       gnt_en, gnt_sel, grant, arvalid_c, rready_c, beat_acc;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [7:0]                 len_q, beat_cnt;
  logic [2:0]                 size_q;
  logic [1:0]                 burst_q;
  logic                       unused_rid;

  assign req_valid = {req1_valid, req0_valid};
  assign req_addr  = {req1_addr, req0_addr};
  assign req_len   = {req1_len, req0_len};
  assign req_size  = {req1_size, req0_size};
  assign req_burst = {req1_burst, req0_burst};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign {req1_ready, req0_ready} = req_ready;
  assign {rsp1_valid, rsp0_valid} = rsp_valid;

`ifdef AXI_RD_ARB_RR_EN
  logic ptr;
  // Pointer remembers the last winner; a contested cycle goes to the other port.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)    ptr <= 1'b0;
    else if (gnt_en) ptr <= gnt_sel;
  always_comb gnt_sel = (&req_valid) ? ~ptr : req_valid[1];
`else
  always_comb gnt_sel = req_valid[1];
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;

  always_comb begin
    state_n   = state;
    gnt_en    = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    case (state)
      IDLE: if (reset_n && |req_valid) begin
        gnt_en             = 1'b1;
        req_ready[gnt_sel] = 1'b1;
        state_n            = ADDR;
      end
      ADDR: begin
        arvalid_c = 1'b1;
        if (m_axi.arready) state_n = DATA;
      end
      DATA: begin
        rsp_valid[grant] = m_axi.rvalid;
        rready_c         = rsp_ready[grant];
        if (m_axi.rvalid && rready_c && m_axi.rlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign beat_acc = (state == DATA) && m_axi.rvalid && rready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      id_err   <= 1'b0;
    end else begin
      if (gnt_en) begin
        grant    <= gnt_sel;
        addr_q   <= req_addr[gnt_sel];
        len_q    <= req_len[gnt_sel];
        size_q   <= req_size[gnt_sel];
        burst_q  <= req_burst[gnt_sel];
        beat_cnt <= '0;
      end
      if (beat_acc) begin
        // beat_cnt is the index of this beat: rlast belongs exactly at index len_q.
        if (m_axi.rid[0] != grant) id_err <= 1'b1;
        if (m_axi.rlast ? (beat_cnt != len_q) : (beat_cnt >= len_q)) id_err <= 1'b1;
        if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  assign m_axi.arid    = {{(ID_WIDTH-1){1'b0}}, grant};
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = burst_q;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_c;
  assign m_axi.rready  = rready_c;

  assign rsp0_data = m_axi.rdata;
  assign rsp1_data = m_axi.rdata;
  assign rsp0_resp = m_axi.rresp;
  assign rsp1_resp = m_axi.rresp;
  assign rsp0_last = m_axi.rlast;
  assign rsp1_last = m_axi.rlast;
  assign unused_rid = ^m_axi.rid;

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR and response beats are queued at stimulus time
// and popped by an independent negedge monitor.
module tb_axi_rd_arbiter;
  localparam int IW = 13, AW = 64, DW = 64;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]    req0_len = '0, req1_len = '0;
  logic [2:0]    req0_size = '0, req1_size = '0;
  logic [1:0]    req0_burst = '0, req1_burst = '0;
  logic          rsp0_valid, rsp1_valid, rsp0_last, rsp1_last;
  logic          rsp0_ready = 1, rsp1_ready = 1;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [1:0]    rsp0_resp, rsp1_resp;
  logic          busy, id_err;
  logic          toggle1 = 0;

  axi_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_size(req0_size), .req0_burst(req0_burst),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_size(req1_size), .req1_burst(req1_burst),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_resp(rsp0_resp),
    .rsp0_last(rsp0_last),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_resp(rsp1_resp),
    .rsp1_last(rsp1_last),
    .m_axi(axi.master), .busy(busy), .id_err(id_err)
  );

  typedef struct {
    logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
  } ar_t;
  typedef struct { int port; logic [DW-1:0] data; logic last; } rsp_t;

  ar_t  exp_ar[$];
  rsp_t exp_rsp[$];
  ar_t  mon_ar;
  rsp_t mon_rsp;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_rsp(input int port, input logic [DW-1:0] data, input logic last);
    if (exp_rsp.size() == 0) chk("rsp_extra_beat", 1, 0);
    else begin
      mon_rsp = exp_rsp.pop_front();
      chk("rsp_port", port, mon_rsp.port);
      chk("rsp_data", data, mon_rsp.data);
      chk("rsp_last", last, mon_rsp.last);
    end
  endtask

  // Monitor: independent of stimulus, compares every AR handshake and delivered beat.
  always @(negedge clk) begin
    if (reset_n) begin
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
        else begin
          mon_ar = exp_ar.pop_front();
          chk("arid", axi.arid, mon_ar.id);
          chk("araddr", axi.araddr, mon_ar.addr);
          chk("arlen", axi.arlen, mon_ar.len);
          chk("arsize", axi.arsize, mon_ar.size);
          chk("arburst", axi.arburst, mon_ar.burst);
          chk("arcache", axi.arcache, 4'b0011);
          chk("arlock_arprot", {axi.arlock, axi.arprot}, 4'b0000);
        end
      end
      if (rsp0_valid && rsp0_ready) check_rsp(0, rsp0_data, rsp0_last);
      if (rsp1_valid && rsp1_ready) check_rsp(1, rsp1_data, rsp1_last);
    end
  end

  task automatic push_ar(input int id, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    ar_t e;
    e.id = IW'(id); e.addr = a; e.len = l; e.size = s; e.burst = b;
    exp_ar.push_back(e);
  endtask

  task automatic push_rsp(input int port, input logic [DW-1:0] base, input int n, input int last_idx);
    rsp_t e;
    for (int b = 0; b < n; b++) begin
      e.port = port; e.data = base + DW'(b); e.last = (b == last_idx);
      exp_rsp.push_back(e);
    end
  endtask

  task automatic issue_req(input int port, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
    int n;
    logic got;
    if (port == 0) begin req0_addr = a; req0_len = l; req0_size = s; req0_burst = b; req0_valid = 1; end
    else           begin req1_addr = a; req1_len = l; req1_size = s; req1_burst = b; req1_valid = 1; end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = (port == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!got) chk("req_ready_timeout", 0, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
  endtask

  // AXI slave model: optional arready stall, then nbeats beats; rst_beat>=0 asserts reset on that beat.
  task automatic slave_burst(input int ar_wait, input int nbeats, input int last_idx, input int rid_v,
                             input logic [DW-1:0] base, input int rst_beat, input int g);
    int  n;
    logic hs;
    n = 0;
    while (!axi.arvalid && n < 20) begin tick(); n++; end
    if (!axi.arvalid) begin chk("arvalid_timeout", 0, 1); return; end
    for (int w = 0; w < ar_wait; w++) begin
      tick();
      chk("ar_hold_valid", axi.arvalid, 1);
      if (exp_ar.size() != 0) begin
        chk("ar_hold_addr", axi.araddr, exp_ar[0].addr);
        chk("ar_hold_len", axi.arlen, exp_ar[0].len);
      end
    end
    axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int b = 0; b < nbeats; b++) begin
      axi.rvalid = 1; axi.rdata = base + DW'(b); axi.rlast = (b == last_idx);
      axi.rid = IW'(rid_v); axi.rresp = 2'b00;
      if (b == rst_beat) begin
        reset_n = 0;
        #1;
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        axi.rvalid = 0; axi.rlast = 0;
        return;
      end
      n = 0; hs = 0;
      while (!hs && n < 20) begin
        @(negedge clk);
        hs = axi.rready;
        chk("rready_mirror", axi.rready, (g == 1) ? rsp1_ready : rsp0_ready);
        tick();
        n++;
        if (toggle1) rsp1_ready = ~rsp1_ready;
      end
      if (!hs) chk("beat_timeout", 0, 1);
    end
    axi.rvalid = 0; axi.rlast = 0;
  endtask

  initial begin
    int w, exp_w, n;
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;

    // Reset state, including ready gated while a request is pending under reset.
    #12;
    req0_valid = 1; #1;
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_rready", axi.rready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_id_err", id_err, 0);
    chk("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    req0_valid = 0;
    tick(); reset_n = 1; tick();

    // Single 8-beat INCR... WRAP burst on port 0, immediate arready.
    push_ar(0, 64'h1000, 8'd7, 3'd2, 2'd2);
    push_rsp(0, 64'hA000, 8, 7);
    issue_req(0, 64'h1000, 8'd7, 3'd2, 2'd2);
    slave_burst(0, 8, 7, 0, 64'hA000, -1, 0);
    chk("single_busy_idle", busy, 0);
    chk("single_id_err", id_err, 0);

    // Early rlast on beat 3 of a len=7 burst.
    push_ar(1, 64'h5000, 8'd7, 3'd3, 2'd1);
    push_rsp(1, 64'hB000, 3, 2);
    issue_req(1, 64'h5000, 8'd7, 3'd3, 2'd1);
    slave_burst(0, 3, 2, 1, 64'hB000, -1, 1);
    chk("early_last_idle", busy, 0);
    chk("early_last_id_err", id_err, 1);

    // rsp1_ready toggling during a 4-beat burst; id_err must stay sticky.
    rsp1_ready = 0; toggle1 = 1;
    push_ar(1, 64'h6000, 8'd3, 3'd3, 2'd1);
    push_rsp(1, 64'hD000, 4, 3);
    issue_req(1, 64'h6000, 8'd3, 3'd3, 2'd1);
    slave_burst(0, 4, 3, 1, 64'hD000, -1, 1);
    toggle1 = 0; rsp1_ready = 1;
    chk("bp_id_err_sticky", id_err, 1);

    // Reset on the 3rd beat of an 8-beat burst: only two beats are ever delivered.
    push_ar(0, 64'h7000, 8'd7, 3'd3, 2'd1);
    push_rsp(0, 64'hE000, 2, 7);
    issue_req(0, 64'h7000, 8'd7, 3'd3, 2'd1);
    slave_burst(0, 8, 7, 0, 64'hE000, 2, 0);
    chk("rst_id_err_clear", id_err, 0);
    tick(); reset_n = 1; tick();

    // rid[0] mismatch: beat still forwarded to port 1, id_err set.
    push_ar(1, 64'h8000, 8'd0, 3'd3, 2'd1);
    push_rsp(1, 64'hF000, 1, 0);
    issue_req(1, 64'h8000, 8'd0, 3'd3, 2'd1);
    slave_burst(0, 1, 0, 0, 64'hF000, -1, 1);
    chk("rid_mismatch_id_err", id_err, 1);

    // arready stalled 5 cycles.
    push_ar(0, 64'h9000, 8'd1, 3'd2, 2'd1);
    push_rsp(0, 64'h9100, 2, 1);
    issue_req(0, 64'h9000, 8'd1, 3'd2, 2'd1);
    slave_burst(5, 2, 1, 0, 64'h9100, -1, 0);
    chk("stall_busy_idle", busy, 0);

    // Fresh reset so the pointer starts at 0, then 4 contested bursts.
    reset_n = 0; tick(); reset_n = 1; tick();
    chk("pulse_id_err_clear", id_err, 0);
    req0_addr = 64'h2000; req0_len = 8'd1; req0_size = 3'd3; req0_burst = 2'd1;
    req1_addr = 64'h3000; req1_len = 8'd1; req1_size = 3'd3; req1_burst = 2'd1;
    req0_valid = 1; req1_valid = 1;
    for (int r = 0; r < 4; r++) begin
`ifdef AXI_RD_ARB_RR_EN
      exp_w = (r % 2 == 0) ? 1 : 0;
`else
      exp_w = 1;
`endif
      push_ar(exp_w, (exp_w == 1) ? 64'h3000 : 64'h2000, 8'd1, 3'd3, 2'd1);
      push_rsp(exp_w, 64'hC000 + 64'(r * 16), 2, 1);
      w = -1; n = 0;
      while (w < 0 && n < 20) begin
        @(negedge clk);
        if (req0_ready && req1_ready) w = 2;
        else if (req0_ready) w = 0;
        else if (req1_ready) w = 1;
        n++;
      end
      chk("arb_winner", w, exp_w);
      tick();
      if (r == 3) begin req0_valid = 0; req1_valid = 0; end
      slave_burst(0, 2, 1, exp_w, 64'hC000 + 64'(r * 16), -1, exp_w);
    end

    tick(); tick();
    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
